// File: rtl/codec_cfg_sched.sv
// rtl/codec_cfg_sched.sv - codec I2C control-port scheduler: power-up sequence, round-robin requester writes, NACK retry; optional register shadow under CODEC_CFG_SHADOW_EN
module codec_cfg_sched #(
    parameter int NREQ      = 3,
    parameter int MAX_RETRY = 2
) (
    input  logic                 inclk_i2c,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [16*NREQ-1:0]   req_word,
    output logic [NREQ-1:0]      req_ack,
    output logic                 req_err,
    output logic                 tx_start,
    output logic [15:0]          tx_word,
    input  logic                 tx_busy,
    input  logic                 tx_done,
    input  logic                 tx_nack,
    output logic                 init_done,
    output logic                 busy,
    output logic [7:0]           nack_count
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [2:0] {
        S_INIT_ISSUE,
        S_INIT_WAIT,
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_ACK
    } state_t;

    state_t         state, state_d;
    logic [2:0]     idx, idx_d;
    logic [2:0]     retry, retry_d;
    logic [IW-1:0]  ptr, ptr_d;
    logic [IW-1:0]  gnt, gnt_d;
    logic [15:0]    gnt_word, gnt_word_d;
    logic           tx_start_d;
    logic [15:0]    tx_word_d;
    logic           init_done_d;
    logic           err, err_d;
    logic [7:0]     nack_d;

    logic           found_hi, found_lo, any_req;
    logic [IW-1:0]  pick_hi, pick_lo, pick;
    logic [15:0]    word_hi, word_lo, pick_word;
    logic           shadow_hit;

    // Power-up register sequence; the activate word goes last so the codec
    // only starts once every other register is programmed.
    function automatic logic [15:0] init_word(input logic [2:0] i);
        case (i)
            3'd0:    init_word = 16'h1E00;
            3'd1:    init_word = 16'h0C00;
            3'd2:    init_word = 16'h0E02;
            3'd3:    init_word = 16'h1000;
            3'd4:    init_word = 16'h0A00;
            3'd5:    init_word = 16'h0814;
            default: init_word = 16'h1201;
        endcase
    endfunction

    // Round-robin pick: lowest set request above the pointer, else wrap to the lowest set one.
    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        pick_hi  = '0;
        pick_lo  = '0;
        word_hi  = 16'h0000;
        word_lo  = 16'h0000;
        for (int i = 0; i < NREQ; i++) begin
            if (req[i]) begin
                if (IW'(i) > ptr) begin
                    if (!found_hi) begin
                        found_hi = 1'b1;
                        pick_hi  = IW'(i);
                        word_hi  = req_word[16*i +: 16];
                    end
                end else if (!found_lo) begin
                    found_lo = 1'b1;
                    pick_lo  = IW'(i);
                    word_lo  = req_word[16*i +: 16];
                end
            end
        end
        any_req   = found_hi | found_lo;
        pick      = found_hi ? pick_hi : pick_lo;
        pick_word = found_hi ? word_hi : word_lo;
    end

`ifdef CODEC_CFG_SHADOW_EN
    logic [8:0]  sh_data [16];
    logic [15:0] sh_valid;
    logic        wr_ok;

    // A NACK-free tx_done always ends the attempt, so it marks a successful write.
    assign wr_ok      = ((state == S_INIT_WAIT) || (state == S_WAIT)) && tx_done && !tx_nack;
    assign shadow_hit = (pick_word[15:13] == 3'b000) && sh_valid[pick_word[12:9]] &&
                        (sh_data[pick_word[12:9]] == pick_word[8:0]);

    // Shadow of the codec registers; writing the reset register invalidates everything.
    always_ff @(posedge inclk_i2c) begin
        if (rst) begin
            sh_valid <= '0;
        end else if (wr_ok) begin
            if (tx_word[15:9] == 7'h0F) begin
                sh_valid <= '0;
            end else if (tx_word[15:13] == 3'b000) begin
                sh_valid[tx_word[12:9]] <= 1'b1;
                sh_data[tx_word[12:9]]  <= tx_word[8:0];
            end
        end
    end
`else
    assign shadow_hit = 1'b0;
`endif

    // Next-state and registered-output decisions for the scheduler FSM.
    always_comb begin
        state_d     = state;
        idx_d       = idx;
        retry_d     = retry;
        ptr_d       = ptr;
        gnt_d       = gnt;
        gnt_word_d  = gnt_word;
        tx_start_d  = 1'b0;
        tx_word_d   = tx_word;
        init_done_d = init_done;
        err_d       = err;
        nack_d      = nack_count;

        if (((state == S_INIT_WAIT) || (state == S_WAIT)) && tx_done && tx_nack &&
            (nack_count != 8'hFF))
            nack_d = nack_count + 8'd1;

        case (state)
            S_INIT_ISSUE: begin
                if (!tx_busy) begin
                    tx_start_d = 1'b1;
                    tx_word_d  = init_word(idx);
                    state_d    = S_INIT_WAIT;
                end
            end
            S_INIT_WAIT: begin
                if (tx_done) begin
                    if (tx_nack && (retry < 3'(MAX_RETRY))) begin
                        retry_d = retry + 3'd1;
                        state_d = S_INIT_ISSUE;
                    end else begin
                        retry_d = 3'd0;
                        if (idx == 3'd6) begin
                            init_done_d = 1'b1;
                            state_d     = S_IDLE;
                        end else begin
                            idx_d   = idx + 3'd1;
                            state_d = S_INIT_ISSUE;
                        end
                    end
                end
            end
            S_IDLE: begin
                if (any_req) begin
                    gnt_d      = pick;
                    gnt_word_d = pick_word;
                    ptr_d      = pick;
                    err_d      = 1'b0;
                    state_d    = shadow_hit ? S_ACK : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (!tx_busy) begin
                    tx_start_d = 1'b1;
                    tx_word_d  = gnt_word;
                    state_d    = S_WAIT;
                end
            end
            S_WAIT: begin
                if (tx_done) begin
                    if (tx_nack && (retry < 3'(MAX_RETRY))) begin
                        retry_d = retry + 3'd1;
                        state_d = S_ISSUE;
                    end else begin
                        err_d   = tx_nack;
                        state_d = S_ACK;
                    end
                end
            end
            S_ACK: begin
                retry_d = 3'd0;
                state_d = S_IDLE;
            end
            default: state_d = S_INIT_ISSUE;
        endcase
    end

    // State and output registers; reset drops any granted write and restarts init.
    always_ff @(posedge inclk_i2c) begin
        if (rst) begin
            state      <= S_INIT_ISSUE;
            idx        <= 3'd0;
            retry      <= 3'd0;
            ptr        <= IW'(NREQ - 1);
            gnt        <= '0;
            gnt_word   <= 16'h0000;
            tx_start   <= 1'b0;
            tx_word    <= 16'h0000;
            init_done  <= 1'b0;
            err        <= 1'b0;
            nack_count <= 8'd0;
        end else begin
            state      <= state_d;
            idx        <= idx_d;
            retry      <= retry_d;
            ptr        <= ptr_d;
            gnt        <= gnt_d;
            gnt_word   <= gnt_word_d;
            tx_start   <= tx_start_d;
            tx_word    <= tx_word_d;
            init_done  <= init_done_d;
            err        <= err_d;
            nack_count <= nack_d;
        end
    end

    // Completion pulse and status decoded from the registered state.
    always_comb begin
        req_ack = '0;
        if (state == S_ACK)
            req_ack[gnt] = 1'b1;
        req_err = (state == S_ACK) && err;
        busy    = (state != S_IDLE);
    end

endmodule

// File: doc/codec_cfg_sched.md
Name: codec_cfg_sched

Overview:
Scheduler that owns the codec's I2C control port. After reset it plays a fixed power-up register sequence. It then arbitrates codec register writes from NREQ independent requesters, such as the boost/line/gain logic and the TX/RX switch logic, and serialises them one word at a time into a word-level I2C transmitter. It retries NACKed writes, reports completion per requester, and exposes init and busy status.

Parameters:
NREQ, 3, number of requesters (1..8)
MAX_RETRY, 2, extra attempts after a NACK before a word is abandoned (0..7)

Ports:
inclk_i2c  in  1  block clock; same clock as the I2C transmitter
rst  in  1  synchronous, active-high reset
req  in  NREQ  per-requester write request level
req_word  in  16*NREQ  requester i word at bits [16i+15:16i]; {reg_addr[6:0], data[8:0]}
req_ack  out  NREQ  one-cycle completion pulse per requester
req_err  out  1  valid with any req_ack bit; 1 = word abandoned after retries
tx_start  out  1  one-cycle pulse; transmitter latches tx_word
tx_word  out  16  word to send
tx_busy  in  1  transmitter busy
tx_done  in  1  one-cycle pulse when the transaction ends
tx_nack  in  1  qualifies tx_done; 1 = any ACK slot was NACKed
init_done  out  1  high once the init sequence has finished
busy  out  1  high in every state except S_IDLE
nack_count  out  8  saturating count of NACKed attempts

Behaviour:
- Reset values, applied on any clock edge with rst=1, including mid-transaction:
  - state=S_INIT_ISSUE, init index=0, retry count=0, round-robin pointer=NREQ-1.
  - Outputs: tx_start=0, tx_word=0, req_ack=0, req_err=0, init_done=0, busy=1, nack_count=0.
  - Any granted request is dropped with no ack. The init sequence runs again.
- Init table, index 0..6: 16'h1E00, 16'h0C00, 16'h0E02, 16'h1000, 16'h0A00, 16'h0814, 16'h1201. The activate word is last.
- States:
  - S_INIT_ISSUE: wait until tx_busy=0, then pulse tx_start with tx_word=table[idx]; go to S_INIT_WAIT.
  - S_INIT_WAIT: on tx_done:
    - tx_nack=1 and retries<MAX_RETRY: retries+1, go to S_INIT_ISSUE, same idx.
    - Otherwise: retries=0. If idx==6, set init_done=1 and go to S_IDLE. Else idx+1 and go to S_INIT_ISSUE.
    - Init never stalls permanently on a dead bus.
  - S_IDLE: if any req bit is set, grant the first set bit strictly after the pointer, scanning with wrap. Latch that requester's index and word, set pointer=granted index, go to S_ISSUE.
  - S_ISSUE: wait until tx_busy=0, then pulse tx_start with the latched word; go to S_WAIT.
  - S_WAIT: on tx_done:
    - tx_nack=1 and retries<MAX_RETRY: retries+1, go to S_ISSUE.
    - Otherwise: go to S_ACK, with err=tx_nack.
  - S_ACK: pulse req_ack[granted] for 1 cycle, with req_err. retries=0. Go to S_IDLE.
- Latency with tx_busy=0: req is sampled high at edge N (S_IDLE), tx_start is high during cycle N+1, and req_ack is high in the cycle after the edge that samples tx_done.
- tx_word is held stable from the tx_start cycle until tx_done. tx_start never fires while tx_busy=1 or while a transaction is outstanding.
- Requesters hold req and their word until ack.
  - req dropping before grant withdraws the request.
  - req dropping after grant is ignored; the write completes and ack still pulses.
  - The word is latched at grant, so later changes to it are not sent.
- Requests are ignored until init_done=1.
- tx_done arriving outside a WAIT state is ignored.
- nack_count increments on every tx_done with tx_nack=1 and saturates at 255.
- Fairness: with all requesters continuously asserted, grants rotate 0,1,2,0,...

Optional Feature:
Macro CODEC_CFG_SHADOW_EN.
- Defined:
  - Adds a 16-entry shadow of 9-bit data plus valid bits, indexed by reg_addr[3:0].
  - Every successful write (no final NACK), init or requester, updates the shadow.
  - A write to reg 0x0F (reset register) clears all valid bits.
  - In S_IDLE, a granted word with reg_addr<16 that matches a valid shadow entry goes directly to S_ACK with req_err=0 and no tx_start.
- Undefined: no shadow; every granted word is transmitted.

Test Plan:
- Reset, then a transmitter model that ACKs everything with tx_done 40 cycles after tx_start → exactly 7 tx_start pulses with words 1E00, 0C00, 0E02, 1000, 0A00, 0814, 1201 in order; init_done rises after the 7th tx_done; busy then falls.
- After init, req=3'b111 held, words 0x0001/0x0E12/0x0C40 → sends in order 0x0001, 0x0E12, 0x0C40; req_ack pulses 001, 010, 100, one per transaction.
- Requester 1 writes 0x0A08 and the model NACKs the first two attempts, MAX_RETRY=2 → three tx_start pulses; ack with req_err=0; nack_count=2.
- Requester 0 writes 0x0801 with the model always NACKing → 3 attempts, then req_ack[0] with req_err=1; nack_count=3; the next request is serviced normally.
- rst asserted for 1 cycle while in S_WAIT of a requester write → no req_ack; init_done=0; the init sequence restarts at 1E00 once tx_busy is low.
- CODEC_CFG_SHADOW_EN defined, requester 2 writes 0x0C40 twice → first write sends 1 tx_start; second write gives req_ack 2 cycles after req with no tx_start. Undefined → 2 tx_start.
